// File: rtl/game_status_tx.sv
`default_nettype none
// game_status_tx: UART 8N1 transmitter of the ASCII status frame "S<s>F<cccc>T<ttt>\r\n"; Rev 1.0
// Defining GAME_TX_CSUM_EN inserts a 2-char XOR checksum of all preceding frame bytes before CR LF.
module game_status_tx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        report_req,
  input  logic [1:0]  state,
  input  logic [15:0] card_find,
  input  logic [11:0] left_time,
  output logic        tx_pin,
  output logic        busy,
  output logic        frame_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef GAME_TX_CSUM_EN
  localparam int NUM_BYTES    = 15;
`else
  localparam int NUM_BYTES    = 13;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BYTE_LAST = 4'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  tx_state_t st, st_next;

  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [3:0]       byte_idx;
  logic [7:0]       shreg;
  logic             pending;
  logic [1:0]       state_prev;
  logic [1:0]       snap_state;
  logic [15:0]      snap_card;
  logic [11:0]      snap_time;
  logic [7:0]       cur_byte;
  logic             trig;
  logic             bit_end;
  logic             frame_end;
  logic             launch;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign trig      = report_req | (state != state_prev);
  assign bit_end   = (clk_cnt == CNT_LAST);
  assign frame_end = (st == STOP) && bit_end && (byte_idx == BYTE_LAST);
  // A trigger landing on the final stop-bit cycle chains straight into the next frame.
  assign launch    = ((st == IDLE) && trig) || (frame_end && (pending || trig));

`ifdef GAME_TX_CSUM_EN
  logic [7:0] csum;
  assign csum = 8'h53 ^ (8'h30 + {6'd0, snap_state}) ^ 8'h46
              ^ hex_char(snap_card[15:12]) ^ hex_char(snap_card[11:8])
              ^ hex_char(snap_card[7:4])   ^ hex_char(snap_card[3:0])
              ^ 8'h54
              ^ hex_char(snap_time[11:8])  ^ hex_char(snap_time[7:4])
              ^ hex_char(snap_time[3:0]);
`endif

  always_comb begin
    cur_byte = 8'h0D;
    case (byte_idx)
      4'd0:  cur_byte = 8'h53;
      4'd1:  cur_byte = 8'h30 + {6'd0, snap_state};
      4'd2:  cur_byte = 8'h46;
      4'd3:  cur_byte = hex_char(snap_card[15:12]);
      4'd4:  cur_byte = hex_char(snap_card[11:8]);
      4'd5:  cur_byte = hex_char(snap_card[7:4]);
      4'd6:  cur_byte = hex_char(snap_card[3:0]);
      4'd7:  cur_byte = 8'h54;
      4'd8:  cur_byte = hex_char(snap_time[11:8]);
      4'd9:  cur_byte = hex_char(snap_time[7:4]);
      4'd10: cur_byte = hex_char(snap_time[3:0]);
`ifdef GAME_TX_CSUM_EN
      4'd11: cur_byte = hex_char(csum[7:4]);
      4'd12: cur_byte = hex_char(csum[3:0]);
      4'd13: cur_byte = 8'h0D;
      4'd14: cur_byte = 8'h0A;
`else
      4'd11: cur_byte = 8'h0D;
      4'd12: cur_byte = 8'h0A;
`endif
      default: cur_byte = 8'h0D;
    endcase
  end

  always_comb begin
    st_next    = st;
    tx_pin     = 1'b1;
    busy       = (st != IDLE);
    frame_done = frame_end;
    case (st)
      IDLE:  if (trig) st_next = START;
      START: begin
        tx_pin = 1'b0;
        if (bit_end) st_next = DATA;
      end
      DATA: begin
        tx_pin = shreg[0];
        if (bit_end && (bit_idx == 3'd7)) st_next = STOP;
      end
      STOP: begin
        if (bit_end) st_next = ((byte_idx != BYTE_LAST) || pending || trig) ? START : IDLE;
      end
      default: st_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      pending    <= 1'b0;
      state_prev <= '0;
      snap_state <= '0;
      snap_card  <= '0;
      snap_time  <= '0;
    end else begin
      st         <= st_next;
      state_prev <= state;

      if ((st == IDLE) || bit_end) clk_cnt <= '0;
      else                         clk_cnt <= clk_cnt + 1'b1;

      if (launch) begin
        snap_state <= state;
        snap_card  <= card_find;
        snap_time  <= left_time;
        byte_idx   <= '0;
      end else if ((st == STOP) && bit_end) begin
        byte_idx <= (byte_idx == BYTE_LAST) ? 4'd0 : byte_idx + 4'd1;
      end

      // Byte is latched at the end of its start bit, so the snapshot has settled by then.
      if ((st == START) && bit_end) begin
        shreg   <= cur_byte;
        bit_idx <= '0;
      end else if ((st == DATA) && bit_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end

      if (launch)                    pending <= 1'b0;
      else if ((st != IDLE) && trig) pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_status_tx.sv
`default_nettype none
// tb_game_status_tx: scoreboard bench; a UART monitor decodes tx_pin and pops expected frame bytes.
module tb_game_status_tx;

  localparam int CPB = 10;
`ifdef GAME_TX_CSUM_EN
  localparam int NB = 15;
`else
  localparam int NB = 13;
`endif
  localparam int FRAME_CYC = 10 * NB * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        report_req = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [15:0] card_find = 16'h0;
  logic [11:0] left_time = 12'h0;
  logic        tx_pin, busy, frame_done;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  game_status_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .report_req(report_req), .state(state),
    .card_find(card_find), .left_time(left_time),
    .tx_pin(tx_pin), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy)       busy_cyc <= busy_cyc + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'd0, n};
    return 8'h41 + ({4'd0, n} - 8'd10);
  endfunction

  task automatic push_frame(input logic [1:0] s, input logic [15:0] c, input logic [11:0] t);
    logic [7:0] f[$];
    logic [7:0] x;
    f.push_back(8'h53); f.push_back(8'h30 + {6'd0, s}); f.push_back(8'h46);
    f.push_back(hexc(c[15:12])); f.push_back(hexc(c[11:8]));
    f.push_back(hexc(c[7:4]));   f.push_back(hexc(c[3:0]));
    f.push_back(8'h54);
    f.push_back(hexc(t[11:8])); f.push_back(hexc(t[7:4])); f.push_back(hexc(t[3:0]));
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
`ifdef GAME_TX_CSUM_EN
    f.push_back(hexc(x[7:4])); f.push_back(hexc(x[3:0]));
`endif
    f.push_back(8'h0D); f.push_back(8'h0A);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 report_req = 1'b1;
    @(posedge clk); #1 report_req = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tx_pin == 1'b0) begin lat = k; break; end
    end
  endtask

  task automatic wait_done(input int limit, input string tag);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    check({tag, "_timeout"}, frame_done, 1);
  endtask

  // UART receiver: sample the middle of every bit, abandoning any byte that overlaps a reset.
  initial begin : uart_mon
    logic [7:0] rx;
    logic       sb, pb, aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx_pin == 1'b0) begin
        aborted = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        sb = tx_pin;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          rx[i] = tx_pin;
        end
        repeat (CPB) @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        pb = tx_pin;
        if (!aborted) begin
          check("rx_start_bit", sb, 0);
          check("rx_stop_bit", pb, 1);
          if (exp_q.size() == 0) check("rx_unexpected_byte", exp_q.size(), 1);
          else                   check("rx_byte", rx, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, b0, d0, bad;

    // Reset and idle line
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tx_pin", tx_pin, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_pin !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Explicit request
    card_find = 16'h00A5; left_time = 12'h12C;
    b0 = busy_cyc; d0 = done_cnt;
    push_frame(2'd0, 16'h00A5, 12'h12C);
    pulse_req();
    wait_done(FRAME_CYC + 50, "req_frame");
    repeat (3) @(negedge clk);
    check("req_busy_cycles", busy_cyc - b0, FRAME_CYC);
    check("req_done_pulses", done_cnt - d0, 1);
    check("req_busy_after", busy, 0);
    check("req_q_drained", exp_q.size(), 0);

    // State change without request; card change mid-frame must not leak in
    b0 = busy_cyc;
    push_frame(2'd2, 16'h00A5, 12'h12C);
    @(posedge clk); #1 state = 2'd2;
    wait_start(lat);
    check("chg_start_latency", lat, 2);
    repeat (30) @(posedge clk);
    #1 card_find = 16'h1234;
    wait_done(FRAME_CYC + 50, "chg_frame");
    repeat (3) @(negedge clk);
    check("chg_busy_cycles", busy_cyc - b0, FRAME_CYC);
    check("chg_q_drained", exp_q.size(), 0);

    // Three requests during a frame merge into one back-to-back frame
    d0 = done_cnt;
    push_frame(2'd2, 16'h1234, 12'h12C);
    pulse_req();
    repeat (150) @(posedge clk);
    #1 left_time = 12'hFED;
    push_frame(2'd2, 16'h1234, 12'hFED);
    pulse_req();
    repeat (200) @(posedge clk);
    pulse_req();
    repeat (200) @(posedge clk);
    pulse_req();
    wait_done(FRAME_CYC + 50, "merge_first");
    @(negedge clk);
    check("merge_gap_busy", busy, 1);
    check("merge_gap_start_bit", tx_pin, 0);
    wait_done(FRAME_CYC + 50, "merge_second");
    repeat (300) @(negedge clk);
    check("merge_done_pulses", done_cnt - d0, 2);
    check("merge_no_third", busy, 0);
    check("merge_q_drained", exp_q.size(), 0);

    // Reset 400 cycles into a frame
    push_frame(2'd2, 16'h1234, 12'hFED);
    pulse_req();
    wait_start(lat);
    check("abort_frame_started", lat, 1);
    repeat (400) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_tx_pin", tx_pin, 1);
    check("abort_busy", busy, 0);
    exp_q.delete();
    state = 2'd0;
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_idle_after", busy, 0);
    b0 = busy_cyc; d0 = done_cnt;
    push_frame(2'd0, 16'h1234, 12'hFED);
    pulse_req();
    wait_done(FRAME_CYC + 50, "post_reset_frame");
    repeat (3) @(negedge clk);
    check("post_busy_cycles", busy_cyc - b0, FRAME_CYC);
    check("post_done_pulses", done_cnt - d0, 1);
    check("post_q_drained", exp_q.size(), 0);

`ifdef GAME_TX_CSUM_EN
    // Checksummed frame triggered by a state change
    b0 = busy_cyc;
    push_frame(2'd1, 16'hFFFF, 12'h000);
    @(posedge clk); #1 card_find = 16'hFFFF; left_time = 12'h000; state = 2'd1;
    wait_done(FRAME_CYC + 50, "csum_frame");
    repeat (3) @(negedge clk);
    check("csum_busy_cycles", busy_cyc - b0, FRAME_CYC);
    check("csum_q_drained", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
